serial_capture_register: RTL

SERIAL_CAPTURE_REGISTER -- requirements
Module: serial_capture_register

---
 rtl/serial_capture_register.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_capture_register.sv
// Serial-to-parallel capture register with a one-word holding register, a valid/ready
// output handshake and a sticky overrun flag. Define SCR_PARITY_EN to add a trailing even-parity bit and the parity_err output.
module serial_capture_register #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sin,
  input  logic                       sin_valid,
  input  logic                       dir,
  input  logic                       flush,
  output logic [WIDTH-1:0]           outp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun
`ifdef SCR_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int CW = $clog2(WIDTH+1);
`ifdef SCR_PARITY_EN
  localparam int LAST = WIDTH;      // the parity bit is the final captured bit
`else
  localparam int LAST = WIDTH - 1;
`endif

  logic [WIDTH-1:0] sreg_reg, sreg_next, shifted, word;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             dir_reg, dir_next, dir_eff;
  logic [WIDTH-1:0] outp_reg, outp_next;
  logic             valid_reg, valid_next;
  logic             ovr_reg, ovr_next;
  logic             perr_reg, perr_next;
  logic             capture, last_bit, word_ok, complete_ok, hold_free;

  always_comb begin
    // bit order is sampled on the first bit of a word and frozen for the rest
    dir_eff  = (cnt_reg == '0) ? dir : dir_reg;
    shifted  = dir_eff ? {sreg_reg[WIDTH-2:0], sin} : {sin, sreg_reg[WIDTH-1:1]};
    capture  = sin_valid && !flush;
    last_bit = capture && (cnt_reg == CW'(LAST));
`ifdef SCR_PARITY_EN
    word     = sreg_reg;
    word_ok  = ~(^{sreg_reg, sin});
`else
    word     = shifted;
    word_ok  = 1'b1;
`endif
    complete_ok = last_bit && word_ok;
    hold_free   = !valid_reg || out_ready;

    sreg_next  = sreg_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    outp_next  = outp_reg;
    valid_next = valid_reg;
    ovr_next   = ovr_reg;
    perr_next  = last_bit && !word_ok;

    if (flush) begin
      sreg_next = '0;
      cnt_next  = '0;
      ovr_next  = 1'b0;
    end else if (capture) begin
      dir_next = dir_eff;
      if (last_bit) begin
        sreg_next = word;
        cnt_next  = '0;
      end else begin
        sreg_next = shifted;
        cnt_next  = cnt_reg + CW'(1);
      end
    end

    if (complete_ok && hold_free) begin
      outp_next  = word;
      valid_next = 1'b1;
    end else if (complete_ok) begin
      ovr_next = 1'b1;
    end else if (valid_reg && out_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_reg  <= '0;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      outp_reg  <= '0;
      valid_reg <= 1'b0;
      ovr_reg   <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      sreg_reg  <= sreg_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      outp_reg  <= outp_next;
      valid_reg <= valid_next;
      ovr_reg   <= ovr_next;
      perr_reg  <= perr_next;
    end
  end

  assign outp      = outp_reg;
  assign out_valid = valid_reg;
  assign bit_cnt   = cnt_reg;
  assign overrun   = ovr_reg;
`ifdef SCR_PARITY_EN
  assign parity_err = perr_reg;
`endif

endmodule
